// File: rtl/fetch_mt.sv
// fetch_mt: round-robin multi-thread fetch/store unit driving one W_ bus
// master port, one outstanding transaction, with an optional ack timeout.
module fetch_mt #(
    parameter int THREADS = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TID_W   = $clog2(THREADS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [THREADS-1:0]        req_valid,
    input  logic [THREADS-1:0]        req_write,
    input  logic [THREADS*ADDR_W-1:0] req_addr,
    input  logic [THREADS*DATA_W-1:0] req_wdata,
    output logic [THREADS-1:0]        req_ready,
    output logic                      resp_valid,
    output logic [TID_W-1:0]          resp_thread,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic                      W_STB,
    output logic                      W_WRITE,
    output logic [ADDR_W-1:0]         W_ADDR,
    output logic [DATA_W-1:0]         W_DATA_O,
    input  logic                      W_ACK,
    input  logic [DATA_W-1:0]         W_DATA_I
);

    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             state, state_n;
    logic [TID_W-1:0]   ptr, ptr_n;
    logic [TID_W-1:0]   owner, owner_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [THREADS-1:0] ready_n;
    logic               rv_n, re_n;
    logic [TID_W-1:0]   rt_n;
    logic [DATA_W-1:0]  rd_n;
    logic               stb_n, wr_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  wdo_n;
    logic [TID_W-1:0]   win, cand;
    logic               found;

    // First pending thread after the last winner, wrapping around.
    always_comb begin
        win   = ptr;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= THREADS; k++) begin
            cand = TID_W'((int'(ptr) + k) % THREADS);
            if (!found && req_valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        ready_n = '0;
        rv_n    = resp_valid;
        rt_n    = resp_thread;
        rd_n    = resp_data;
        re_n    = resp_err;
        stb_n   = W_STB;
        wr_n    = W_WRITE;
        addr_n  = W_ADDR;
        wdo_n   = W_DATA_O;
        unique case (state)
            IDLE: begin
                if (found) begin
                    stb_n        = 1'b1;
                    wr_n         = req_write[win];
                    addr_n       = req_addr[int'(win)*ADDR_W +: ADDR_W];
                    wdo_n        = req_wdata[int'(win)*DATA_W +: DATA_W];
                    ready_n[win] = 1'b1;
                    ptr_n        = win;
                    owner_n      = win;
                    cnt_n        = '0;
                    state_n      = BUS;
                end
            end
            BUS: begin
                if (W_ACK) begin
                    stb_n   = 1'b0;
                    rv_n    = 1'b1;
                    rt_n    = owner;
                    re_n    = 1'b0;
                    rd_n    = W_WRITE ? '0 : W_DATA_I;
                    state_n = RESP;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
                    stb_n   = 1'b0;
                    rv_n    = 1'b1;
                    rt_n    = owner;
                    re_n    = 1'b1;
                    rd_n    = '0;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                rv_n    = 1'b0;
                re_n    = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= TID_W'(THREADS - 1);
            owner       <= '0;
            cnt         <= '0;
            req_ready   <= '0;
            resp_valid  <= 1'b0;
            resp_thread <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            W_STB       <= 1'b0;
            W_WRITE     <= 1'b0;
            W_ADDR      <= '0;
            W_DATA_O    <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            cnt         <= cnt_n;
            req_ready   <= ready_n;
            resp_valid  <= rv_n;
            resp_thread <= rt_n;
            resp_data   <= rd_n;
            resp_err    <= re_n;
            W_STB       <= stb_n;
            W_WRITE     <= wr_n;
            W_ADDR      <= addr_n;
            W_DATA_O    <= wdo_n;
        end
    end

endmodule

// File: tb/tb_fetch_mt.sv
// tb_fetch_mt: randomized thread/bus traffic against a queue-based
// round-robin reference with a response scoreboard.
`timescale 1ns/1ps
module tb_fetch_mt;

    localparam int T  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [T-1:0]    req_valid = '0;
    logic [T-1:0]    req_write = '0;
    logic [T*AW-1:0] req_addr = '0;
    logic [T*DW-1:0] req_wdata = '0;
    logic [T-1:0]    req_ready;
    logic            resp_valid;
    logic [TW-1:0]   resp_thread;
    logic [DW-1:0]   resp_data;
    logic            resp_err;
    logic            W_STB, W_WRITE;
    logic [AW-1:0]   W_ADDR;
    logic [DW-1:0]   W_DATA_O;
    logic            W_ACK = 1'b0;
    logic [DW-1:0]   W_DATA_I = '0;

    fetch_mt #(.THREADS(T), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_thread(resp_thread),
        .resp_data(resp_data), .resp_err(resp_err),
        .W_STB(W_STB), .W_WRITE(W_WRITE), .W_ADDR(W_ADDR),
        .W_DATA_O(W_DATA_O), .W_ACK(W_ACK), .W_DATA_I(W_DATA_I)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tid;
        logic [DW-1:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // stimulus knobs
    bit drv_en = 0;
    bit cancel_en = 0;
    bit mode_never = 0;
    bit stray_all = 0;
    int p_new = 0;
    bit waiting[T];

    // reference model of the arbiter / current transaction
    logic [T-1:0]  rv_q = '0;
    int            last = T - 1;
    bit            inflight = 0;
    int            cur_tid, cur_wait, wait_left, stb_cnt, age, stall;
    bit            cur_write, cur_never, cur_acked;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;

    always @(posedge clk) rv_q <= req_valid;

    // thread drivers
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < T; i++) begin
                    if (resp_valid && int'(resp_thread) == i)
                        waiting[i] = 0;
                    if (req_valid[i] && req_ready[i]) begin
                        req_valid[i] = 1'b0;
                        waiting[i] = 1;
                    end else if (req_valid[i]) begin
                        if (drv_en && cancel_en && $urandom_range(0, 15) == 0)
                            req_valid[i] = 1'b0;
                    end else if (drv_en && !waiting[i] &&
                                 $urandom_range(0, 99) < p_new) begin
                        req_valid[i] = 1'b1;
                        req_write[i] = 1'($urandom_range(0, 1));
                        req_addr[i*AW +: AW] = $urandom;
                        req_wdata[i*DW +: DW] = $urandom;
                    end
                end
            end
        end
    end

    // arbiter model, bus hold checks and bus responder
    initial begin
        int ew, c, exp_len;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (resp_valid && inflight) begin
                    checks++;
                    exp_len = cur_never ? TO : cur_wait + 1;
                    if (stb_cnt != exp_len) begin
                        errors++;
                        $display("FAIL stb_len thread %0d: got %0d cycles, expected %0d",
                                 cur_tid, stb_cnt, exp_len);
                    end
                    inflight = 0;
                end
                if (req_ready != '0) begin
                    checks++;
                    ew = -1;
                    for (int k = 1; k <= T; k++) begin
                        c = (last + k) % T;
                        if (ew < 0 && rv_q[c]) ew = c;
                    end
                    if (inflight || ew < 0 || req_ready != (T'(1) << ew)) begin
                        errors++;
                        $display("FAIL grant: got req_ready=%b, expected thread %0d (pending %b, busy %0d)",
                                 req_ready, ew, rv_q, inflight);
                    end
                    if (ew >= 0) begin
                        last = ew;
                        inflight = 1;
                        cur_tid = ew;
                        cur_write = req_write[ew];
                        cur_addr = req_addr[ew*AW +: AW];
                        cur_wdata = req_wdata[ew*DW +: DW];
                        cur_never = mode_never || $urandom_range(0, 9) == 0;
                        cur_wait = $urandom_range(0, 3);
                        wait_left = cur_wait;
                        cur_acked = 0;
                        stb_cnt = 0;
                        age = 0;
                        if (cur_never) exp_q.push_back('{ew, '0, 1'b1});
                    end
                end
                if (W_STB) begin
                    checks++;
                    if (!inflight || W_WRITE !== cur_write || W_ADDR !== cur_addr ||
                        W_DATA_O !== cur_wdata) begin
                        errors++;
                        $display("FAIL bus_hold: got wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h busy=%0d",
                                 W_WRITE, W_ADDR, W_DATA_O, cur_write, cur_addr, cur_wdata, inflight);
                    end
                    stb_cnt++;
                end
                if (inflight) begin
                    age++;
                    if (age > TO + 8) begin
                        checks++;
                        errors++;
                        $display("FAIL no_completion thread %0d: got none after %0d cycles, expected within %0d",
                                 cur_tid, age, TO + 2);
                        inflight = 0;
                    end
                end
                if (rv_q != '0 && !inflight && req_ready == '0) stall++;
                else stall = 0;
                if (stall > 3) begin
                    checks++;
                    errors++;
                    $display("FAIL stall: got no grant for %0d cycles, expected grant of pending %b",
                             stall, rv_q);
                    stall = 0;
                end
                W_DATA_I = $urandom;
                if (W_STB && inflight && !cur_acked && !cur_never) begin
                    if (wait_left == 0) begin
                        W_ACK = 1'b1;
                        cur_acked = 1;
                        exp_q.push_back('{cur_tid, cur_write ? '0 : W_DATA_I, 1'b0});
                    end else begin
                        W_ACK = 1'b0;
                        wait_left--;
                    end
                end else begin
                    W_ACK = !W_STB && (stray_all || $urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // response monitor
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got thread %0d data %h err %b, expected none",
                             resp_thread, resp_data, resp_err);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(resp_thread) != e.tid || resp_data !== e.data ||
                        resp_err !== e.err) begin
                        errors++;
                        $display("FAIL resp: got thread %0d data %h err %b, expected thread %0d data %h err %b",
                                 resp_thread, resp_data, resp_err, e.tid, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic clear_model();
        drv_en = 0;
        req_valid = '0;
        W_ACK = 1'b0;
        for (int i = 0; i < T; i++) waiting[i] = 0;
        exp_q.delete();
        inflight = 0;
        last = T - 1;
        stall = 0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit done;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_w_stb", 64'(W_STB), 64'd0);
        chk("reset_w_addr", 64'(W_ADDR), 64'd0);
        chk("reset_resp_data", 64'(resp_data), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // every thread always requesting: strict 0,1,2,3,0,... rotation
        p_new = 100; cancel_en = 0; drv_en = 1;
        run(60);
        // mixed random traffic with cancellations
        p_new = 30; cancel_en = 1;
        run(1500);
        // bus never acks: every transaction times out
        mode_never = 1;
        run(150);
        mode_never = 0;

        // async reset in the middle of a bus cycle
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = W_STB;
        end
        chk("reset_mid_found_stb", 64'(done), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_w_stb", 64'(W_STB), 64'd0);
        chk("reset_mid_req_ready", 64'(req_ready), 64'd0);
        chk("reset_mid_resp_valid", 64'(resp_valid), 64'd0);
        clear_model();
        @(negedge clk);
        #2 rst = 1'b0;
        p_new = 100; cancel_en = 0; drv_en = 1;
        run(40);
        p_new = 40; cancel_en = 1;
        run(200);

        // drain
        drv_en = 0;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (req_valid == '0) && !inflight && exp_q.size() == 0 && !resp_valid;
        end
        chk("drain_complete", 64'(done), 64'd1);

        // stray acks with nobody requesting
        stray_all = 1;
        repeat (8) begin
            @(negedge clk);
            chk("idle_w_stb", 64'(W_STB), 64'd0);
            chk("idle_resp_valid", 64'(resp_valid), 64'd0);
        end
        stray_all = 0;
        chk("idle_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_mt.md
Name: fetch_mt

Overview:
Parametrised multi-thread fetch/store unit, successor to the single-port FETCH. It accepts independent read or write requests from THREADS hardware threads and arbitrates them round-robin onto one W_ bus master port. It returns data and completion to the owning thread, tagged with the thread id. It adds a bus-timeout error path so a missing W_ACK cannot hang a thread.

Parameters:
THREADS, 4, number of requesting threads (>=2)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles waiting for W_ACK before error; 0 = never time out
TID_W, $clog2(THREADS), thread id width (derived)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  THREADS  per-thread request pending; held until req_ready
req_write  in  THREADS  per-thread 1=write, 0=read/fetch
req_addr  in  THREADS*ADDR_W  packed addresses, thread i at [i*ADDR_W +: ADDR_W]
req_wdata  in  THREADS*DATA_W  packed write data
req_ready  out  THREADS  one-hot one-cycle pulse: request of thread i accepted
resp_valid  out  1  one-cycle completion pulse
resp_thread  out  TID_W  thread owning the completion
resp_data  out  DATA_W  read data (0 for writes and errors)
resp_err  out  1  completion is a timeout error (valid with resp_valid)
W_STB  out  1  bus cycle active
W_WRITE  out  1  bus write
W_ADDR  out  ADDR_W  bus address
W_DATA_O  out  DATA_W  bus write data
W_ACK  in  1  bus acknowledge
W_DATA_I  in  DATA_W  bus read data

Behaviour:
- Reset (async assert): all outputs 0; FSM=IDLE; rr pointer=THREADS-1, so thread 0 wins first; timeout counter=0. Reset mid-transaction drops W_STB immediately; no response is issued.
- FSM IDLE: if any req_valid, pick the first set bit searching from pointer+1 modulo THREADS. Registered at that edge: W_STB=1, W_WRITE/W_ADDR/W_DATA_O from the winner, req_ready[winner]=1 for exactly one cycle, pointer=winner, owner=winner. Go to BUS. No request: stay.
- FSM BUS: W_STB, W_WRITE, W_ADDR and W_DATA_O are held stable.
  - W_ACK=1: drop W_STB. Register resp_valid=1, resp_thread=owner, resp_err=0, resp_data = W_DATA_I for reads or 0 for writes. Go to RESP.
  - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: drop W_STB. Register resp_valid=1, resp_err=1, resp_data=0. Go to RESP.
  - Else the counter increments. It clears on entering BUS.
- FSM RESP: resp_valid is high this single cycle; then clear resp_valid and resp_err and go to IDLE. A new grant is possible on the following edge.
- Latency: req_valid seen at edge n gives W_STB high after edge n. W_ACK sampled at edge m gives resp_valid high after edge m. The minimum request-to-response is 2 edges with zero-wait ack. Throughput is at most one transaction per 3 cycles.
- W_ACK outside BUS is ignored.
- Simultaneous requests: strict round-robin. A thread that was just served has lowest priority next time.
- Deasserting req_valid before req_ready is allowed and cancels the request. After req_ready the transaction always completes, by ack or by timeout.
- A thread must not present a new request until it has received its resp_valid. Violations are undefined.
- Only one outstanding bus transaction at a time.

Test Plan:
- Reset then thread 2 reads 0x100, W_ACK after 1 wait cycle with W_DATA_I=0xDEADBEEF -> req_ready=4'b0100 pulse; W_ADDR=0x100, W_WRITE=0 while W_STB; resp_valid pulse with resp_thread=2, resp_data=0xDEADBEEF, resp_err=0.
- All 4 threads hold req_valid, zero-wait ack -> grant order 0,1,2,3,0; each req_ready one cycle; no thread starved.
- Thread 1 writes 0x55AA to 0x20 -> W_WRITE=1, W_DATA_O=0x55AA held until ack; resp_data=0, resp_err=0, resp_thread=1.
- TIMEOUT=16, never ack -> W_STB high exactly 16 cycles, then resp_valid with resp_err=1 and resp_data=0; next request is served normally.
- rst pulsed while W_STB=1 -> W_STB, req_ready and resp_valid go 0 asynchronously; no response; first grant after reset goes to thread 0.
- Stray W_ACK in IDLE with no requests -> no resp_valid; W_STB stays 0.
